// File: rtl/alu_divider.sv
// alu_divider: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// It produces one quotient bit per cycle, takes WIDTH cycles in CALC, and
// signals the result with a one-cycle done pulse. Divide-by-zero and signed
// overflow bypass the iteration and finish one cycle after acceptance.
//
// state | meaning
// IDLE  | waiting for start with a divider AluControl code
// CALC  | iterating, one quotient bit per cycle (busy=1)
// DONE  | done=1 for one cycle, result and flags valid
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       AluControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [4:0] DIV_SGN  = 5'b01111;
  localparam logic [4:0] DIV_USGN = 5'b10000;
  localparam logic [4:0] REM_SGN  = 5'b10001;
  localparam logic [4:0] REM_USGN = 5'b10010;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             sel_div_q, neg_quo_q, neg_rem_q;
  logic             busy_q, done_q, dz_q, ov_q;

  logic             op_valid, op_div, op_sgn, b_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quo_d, rem_d, final_res;

  // Request decode plus one restoring step on the current partial remainder.
  always_comb begin
    op_valid    = (AluControl == DIV_SGN) || (AluControl == DIV_USGN) ||
                  (AluControl == REM_SGN) || (AluControl == REM_USGN);
    op_div      = (AluControl == DIV_SGN) || (AluControl == DIV_USGN);
    op_sgn      = (AluControl == DIV_SGN) || (AluControl == REM_SGN);
    b_zero      = (b == '0);
    ovf         = op_sgn && (a == MIN) && (b == '1);
    a_abs       = (op_sgn && a[WIDTH-1]) ? -a : a;
    b_abs       = (op_sgn && b[WIDTH-1]) ? -b : b;
    special_res = b_zero ? (op_div ? '1 : a) : (op_div ? MIN : '0);

    // The shifted remainder needs one extra bit; the borrow is diff's MSB.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    final_res = sel_div_q ? (neg_quo_q ? -quo_d : quo_d)
                          : (neg_rem_q ? -rem_d : rem_d);
  end

  // Sequencer with registered outputs; done and the flags default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      sel_div_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && op_valid) begin
            sel_div_q <= op_div;
            if (b_zero || ovf) begin
              result_q <= special_res;
              dz_q     <= b_zero;
              ov_q     <= ovf;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              quo_q     <= a_abs;
              dvs_q     <= b_abs;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_q <= op_sgn && a[WIDTH-1];
              busy_q    <= 1'b1;
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and randomized checks of alu_divider against a
// plain-arithmetic reference model.
module tb_alu_divider;

  localparam logic [4:0] DIV_SGN  = 5'b01111;
  localparam logic [4:0] DIV_USGN = 5'b10000;
  localparam logic [4:0] REM_SGN  = 5'b10001;
  localparam logic [4:0] REM_USGN = 5'b10010;
  localparam logic [4:0] ADDITION = 5'b00010;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  ctl;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  alu_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .AluControl(ctl),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension division rules with native arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] x, y,
                                output logic [31:0] r, output logic dz, output logic ov,
                                output int lat);
    bit is_div, sgn;
    int sx, sy;
    is_div = (op == DIV_SGN) || (op == DIV_USGN);
    sgn    = (op == DIV_SGN) || (op == REM_SGN);
    sx = int'(x);
    sy = int'(y);
    dz = (y == 0);
    ov = sgn && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (dz)       r = is_div ? 32'hFFFF_FFFF : x;
    else if (ov)  r = is_div ? 32'h8000_0000 : 32'h0;
    else if (sgn) r = is_div ? 32'(sx / sy) : 32'(sx % sy);
    else          r = is_div ? x / y : x % y;
    lat = (dz || ov) ? 1 : 33;
  endfunction

  // Issue one request and follow it until done (bounded); counts busy cycles
  // and any flag seen outside the done cycle.
  task automatic do_op(input logic [4:0] op, input logic [31:0] av, bv,
                       output int lat, output int nbusy, output logic [31:0] r,
                       output logic dz, output logic ov, output int leak);
    @(negedge clk);
    start = 1'b1; ctl = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = -1; nbusy = 0; leak = 0; r = 'x; dz = 1'bx; ov = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = c; r = result; dz = div_by_zero; ov = overflow;
        break;
      end
      if (div_by_zero || overflow) leak++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ctl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0000 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b dz=%b ov=%b result=%h, want all 0",
               busy, done, div_by_zero, overflow, result);
    end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] x, y, r;
    logic        dz, ov;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    int lat, nb, lk;
    logic [31:0] r;
    logic dz, ov;
    v[0]  = '{DIV_USGN, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 33};
    v[1]  = '{REM_USGN, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0, 33};
    v[2]  = '{DIV_SGN,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0, 33};
    v[3]  = '{REM_SGN,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0, 33};
    v[4]  = '{REM_SGN,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0, 33};
    v[5]  = '{DIV_SGN,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 1};
    v[6]  = '{REM_USGN, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0, 1};
    v[7]  = '{DIV_SGN,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1, 1};
    v[8]  = '{REM_SGN,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0, 1'b1, 1};
    v[9]  = '{DIV_USGN, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 33};
    v[10] = '{DIV_SGN,  32'd0,          32'd5,          32'd0,          1'b0, 1'b0, 33};
    v[11] = '{REM_SGN,  32'd0,          32'hFFFF_FFFB,  32'd0,          1'b0, 1'b0, 33};
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].op, v[i].x, v[i].y, lat, nb, r, dz, ov, lk);
      total++;
      if (r !== v[i].r || dz !== v[i].dz || ov !== v[i].ov) begin
        bad++;
        $display("FAIL directed_%0d_result: got r=%h dz=%b ov=%b, want r=%h dz=%b ov=%b",
                 i, r, dz, ov, v[i].r, v[i].dz, v[i].ov);
      end
      total++;
      if (lat != v[i].lat || nb != ((v[i].lat == 33) ? 32 : 0)) begin
        bad++;
        $display("FAIL directed_%0d_timing: got latency=%0d busy_cycles=%0d, want %0d/%0d",
                 i, lat, nb, v[i].lat, (v[i].lat == 33) ? 32 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[4] = '{DIV_SGN, DIV_USGN, REM_SGN, REM_USGN};
    logic [4:0] op;
    logic [31:0] x, y, r, er;
    logic dz, ov, edz, eov;
    int lat, elat, nb, lk, mode;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      mode = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom;
      if (mode == 0) y = 32'h0;
      else if (mode == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (mode < 5) y = $urandom_range(1, 300) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      model(op, x, y, er, edz, eov, elat);
      do_op(op, x, y, lat, nb, r, dz, ov, lk);
      total++;
      if (r !== er || dz !== edz || ov !== eov || lat != elat || lk != 0) begin
        bad++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got r=%h dz=%b ov=%b lat=%0d leak=%0d, want r=%h dz=%b ov=%b lat=%0d leak=0",
                 i, op, x, y, r, dz, ov, lat, lk, er, edz, eov, elat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, ndone;
    logic [31:0] r;
    @(negedge clk);
    start = 1'b1; ctl = DIV_USGN; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = -1; ndone = 0; r = 'x;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin start = 1'b1; ctl = DIV_USGN; a = 32'd9; b = 32'd3; end
      else start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = c; r = result; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (lat != 33 || r !== 32'd14 || ndone != 1) begin
      bad++;
      $display("FAIL start_in_calc: got latency=%0d result=%h dones=%0d, want 33/0000000e/1",
               lat, r, ndone);
    end
    total++;
    if (result !== 32'd14) begin
      bad++;
      $display("FAIL result_hold: got %h, want 0000000e", result);
    end
    @(negedge clk);
    start = 1'b1; ctl = ADDITION; a = 32'd1; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL non_div_code: got %0d cycles with busy/done, want 0", ndone);
    end
  endtask

  task automatic test_reset_abort();
    int lat, nb, lk, ndone;
    logic [31:0] r;
    logic dz, ov;
    @(negedge clk);
    start = 1'b1; ctl = DIV_USGN; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_abort_state: busy=%b done=%b result=%h, want 0/0/00000000",
               busy, done, result);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL reset_abort_no_done: got %0d busy/done cycles, want 0", ndone);
    end
    do_op(DIV_USGN, 32'd9, 32'd3, lat, nb, r, dz, ov, lk);
    total++;
    if (r !== 32'd3 || lat != 33 || nb != 32) begin
      bad++;
      $display("FAIL reset_abort_recover: got r=%h lat=%0d busy=%0d, want 00000003/33/32",
               r, lat, nb);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, r, er;
    logic dz, ov, edz, eov;
    int lat, elat, nb, lk;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = (i % 2 == 0) ? 32'h0 : 32'($urandom_range(1, 1000));
      model(REM_USGN, x, y, er, edz, eov, elat);
      do_op(REM_USGN, x, y, lat, nb, r, dz, ov, lk);
      total++;
      if (r !== er || dz !== edz || lat != elat) begin
        bad++;
        $display("FAIL back_to_back_%0d: got r=%h dz=%b lat=%0d, want r=%h dz=%b lat=%0d",
                 i, r, dz, lat, er, edz, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
